rvfi_dmem_responder: RTL
========================

# rvfi_dmem_responder

Word-organised data-memory responder that serves a core's load/store requests during simulation and formal runs. It drives the read data that the RVFI data-memory consistency check later observes on `rvfi_mem_rdata`. It holds a small byte-writable array, answers each request after a programmable latency, and flags misaligned or out-of-range accesses. Saturating counters report read, write and error traffic for coverage.

## Interface
Parameters:
- XLEN, 32, data width in bits; 32 or 64.
- DEPTH, 16, number of XLEN-bit words; power of two, at least 2.
- BASE, 0, byte address of word 0; aligned to DEPTH*XLEN/8.
- LATENCY, 1, cycles from request acceptance to `rsp_valid`; at least 1.
- FILL_BYTE, 8'h00, value returned for bytes never written since reset.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  XLEN  byte address.
- req_wstrb  in  XLEN/8  byte write enables; all-zero means read.
- req_wdata  in  XLEN  write data, byte lane i is bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  XLEN  read data; 0 for writes and errors.
- rsp_error  out  1  access was misaligned or out of range.
- rd_count  out  16  accepted good reads, saturating at 16'hFFFF.
- wr_count  out  16  accepted good writes, saturating.
- err_count  out  16  accepted erroneous requests, saturating.

## Operation
- The state machine has three states: IDLE, WAIT and RESP.
- `req_ready` is 1 only in IDLE. A request is accepted when `req_valid && req_ready`.
- Let AB = log2(XLEN/8).
  - The request is misaligned if `req_addr[AB-1:0]` is nonzero.
  - It is out of range if `req_addr < BASE` or `req_addr >= BASE + DEPTH*XLEN/8`.
  - Either condition makes it erroneous.
  - The word index is `(req_addr - BASE) >> AB`, truncated to log2(DEPTH) bits.
- On acceptance of a good write:
  - Each lane with its `req_wstrb` bit set is written into the array.
  - That lane's bit in a DEPTH*XLEN/8-bit written bitmap is set.
  - The response data is 0 and `rsp_error` is 0. `wr_count` increments.
- On acceptance of a good read:
  - Each lane returns the stored byte if its written bit is set, otherwise FILL_BYTE.
  - The data is captured at the acceptance edge into the response register.
  - `rsp_error` is 0. `rd_count` increments.
- On acceptance of an erroneous request:
  - There is no array or bitmap update.
  - The response data is 0 and `rsp_error` is 1. `err_count` increments.
- State transitions:
  - IDLE goes to RESP on acceptance if LATENCY is 1; otherwise it goes to WAIT and loads the latency counter with LATENCY-1.
  - WAIT decrements the counter each cycle and goes to RESP when the counter reaches 1.
  - RESP holds `rsp_valid`=1 and keeps `rsp_rdata` and `rsp_error` stable until `rsp_ready`. On that handshake it goes to IDLE.
- A response stalled by `rsp_ready`=0 holds indefinitely. No request is accepted meanwhile.
- A read of a word written by the immediately preceding request returns the new bytes, because the write commits at its own acceptance edge.
- Counters saturate at 16'hFFFF and never wrap.
- The array contents are not reset. Only the bitmap is cleared, so post-reset reads return FILL_BYTE.

## Timing
- Reset values:
  - State is IDLE, so `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0.
  - All counters are 0 and the bitmap is 0.
- If a request is accepted at edge t, `rsp_valid` rises after edge t+LATENCY-1. That is, it is seen high in the cycle following t+LATENCY-1 clocks.
- With LATENCY=1, `rsp_valid` is high in the cycle immediately after acceptance.
- Throughput with `rsp_ready` tied to 1 is one request per LATENCY+1 cycles.
- `req_ready` is low from the cycle after acceptance until the cycle after the response handshake. There is no same-cycle handshake-and-accept.
- A reset asserted in WAIT or RESP discards the pending response next cycle: state returns to IDLE and `rsp_valid` drops to 0.
  - Array writes already committed remain.
  - The bitmap is cleared, so those bytes read back as FILL_BYTE.
- `reset` takes priority over any simultaneous handshake. A request presented in the reset cycle is not accepted and no counter moves.

## Test plan
- Reset, then read at 0x4 with LATENCY=1 -> after 1 cycle `rsp_valid`=1, `rsp_rdata`=0x00000000 (FILL_BYTE=0), `rsp_error`=0, `rd_count`=1.
- Write 0xDEADBEEF to 0x8 with `req_wstrb`=4'b0101, then read 0x8 -> `rsp_rdata`=0x00AD00EF, `wr_count`=1, `rd_count`=1.
- With LATENCY=3, read 0x0 and hold `rsp_ready`=0 for 5 cycles -> `rsp_valid` rises 3 cycles after acceptance, data stays stable and `req_ready`=0 throughout; on the ready handshake `req_ready` returns 1 the next cycle.
- Write to 0x2 (misaligned) and to BASE+0x40 with DEPTH=16 -> both give `rsp_error`=1 and `rsp_rdata`=0, `err_count`=2, a following read of 0x0 returns FILL_BYTE, `wr_count`=0.
- Write 0x11223344 to 0xC, assert reset while the following read of 0xC sits in RESP -> `rsp_valid`=0 next cycle, and a re-read of 0xC returns FILL_BYTE in every lane with counters back at 0.
- Preload `rd_count` to 16'hFFFE via 2 reads past force/long run, then issue 2 more reads -> count reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/rvfi_dmem_responder.sv
// Byte-writable word memory that answers core load/store requests after a fixed latency.
// It flags misaligned and out-of-range accesses and keeps saturating traffic counters.
module rvfi_dmem_responder #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 16,
    parameter logic [XLEN-1:0] BASE      = '0,
    parameter int              LATENCY   = 1,
    parameter logic [7:0]      FILL_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN/8-1:0] req_wstrb,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_error,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic [15:0]       err_count
);

    localparam int NB = XLEN / 8;
    localparam int AB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [XLEN:0] LIMIT = {1'b0, BASE} + (XLEN+1)'(DEPTH * NB);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                        state_q;
    logic [CW-1:0]                 lat_cnt_q;
    logic                          rsp_valid_q;
    logic [XLEN-1:0]               rsp_rdata_q;
    logic                          rsp_error_q;
    logic [DEPTH-1:0][NB-1:0]      map_q;
    logic [DEPTH-1:0][XLEN-1:0]    mem_q;
    logic [15:0]                   rd_cnt_q, wr_cnt_q, err_cnt_q;
    logic [15:0]                   rd_cnt_d, wr_cnt_d, err_cnt_d;

    logic            accept, misaligned, out_of_range, bad, is_write, wr_en, rd_en;
    logic [XLEN-1:0] offs;
    logic [IW-1:0]   idx;
    logic [XLEN-1:0] rd_word, rdata_c;

    assign accept       = req_valid && (state_q == S_IDLE) && !reset;
    assign misaligned   = |req_addr[AB-1:0];
    assign out_of_range = ({1'b0, req_addr} < {1'b0, BASE}) || ({1'b0, req_addr} >= LIMIT);
    assign bad          = misaligned || out_of_range;
    assign is_write     = |req_wstrb;
    assign wr_en        = accept && !bad && is_write;
    assign rd_en        = accept && !bad && !is_write;
    assign offs         = req_addr - BASE;
    assign idx          = IW'(offs >> AB);

    // Lanes never written since reset read back as the fill pattern.
    always_comb begin
        rd_word = mem_q[idx];
        rdata_c = '0;
        for (int i = 0; i < NB; i++)
            rdata_c[8*i +: 8] = map_q[idx][i] ? rd_word[8*i +: 8] : FILL_BYTE;
    end

    always_comb begin
        rd_cnt_d  = rd_cnt_q  + 16'((rd_en && (rd_cnt_q != 16'hFFFF)) ? 1 : 0);
        wr_cnt_d  = wr_cnt_q  + 16'((wr_en && (wr_cnt_q != 16'hFFFF)) ? 1 : 0);
        err_cnt_d = err_cnt_q + 16'((accept && bad && (err_cnt_q != 16'hFFFF)) ? 1 : 0);
    end

    // Array contents survive reset; only the written bitmap is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++)
                if (req_wstrb[i]) mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lat_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            map_q       <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
            if (wr_en) map_q[idx] <= map_q[idx] | req_wstrb;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rsp_rdata_q <= rd_en ? rdata_c : '0;
                        rsp_error_q <= bad;
                        if (LATENCY == 1) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q   <= S_WAIT;
                            lat_cnt_q <= CW'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (lat_cnt_q <= CW'(1)) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign err_count = err_cnt_q;

endmodule
